// File: rtl/tlu_dec_pend.sv
// tlu_dec_pend: indexed set/clear into a registered pending vector with bulk
// overwrite, plus a pick of one pending entry offered on a valid/ack handshake.
// Optional feature macro: TLU_DEC_PEND_RR_EN selects a round-robin pick that
// starts searching at a pointer advanced past each accepted entry; without it
// the pick is fixed priority, lowest index first.
module tlu_dec_pend #(
    parameter  int IDX_W   = 6,
    localparam int NUM_ENT = 2 ** IDX_W
) (
    input  logic               rclk,
    input  logic               arst_l,
    input  logic               set_vld,
    input  logic [IDX_W-1:0]   set_idx,
    input  logic               clr_vld,
    input  logic [IDX_W-1:0]   clr_idx,
    input  logic               wr_vld,
    input  logic [NUM_ENT-1:0] wr_data,
    input  logic               req_ack,
    output logic [NUM_ENT-1:0] pend_vec,
    output logic               req_vld,
    output logic [IDX_W-1:0]   req_idx,
    output logic               dup_set
);

    localparam logic [NUM_ENT-1:0] ONE_HOT0 = NUM_ENT'(1);

    logic [NUM_ENT-1:0] pend_q, pend_d;
    logic               dup_q, dup_d;
    logic [NUM_ENT-1:0] set_dec, clr_dec, ack_dec, clr_mask, base;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_pend;
    logic               ack_acc;

    assign any_pend = |pend_q;
    assign ack_acc  = req_ack & any_pend;

`ifdef TLU_DEC_PEND_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Round-robin pick: first pending entry at or after ptr_q, circularly.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        pick_idx = '0;
        for (int k = NUM_ENT - 1; k >= 0; k--) begin
            if (pend_q[ptr_q + IDX_W'(k)]) begin
                pick_idx = ptr_q + IDX_W'(k);
            end
        end
    end

    // The search start moves just past the entry the consumer accepted.
    assign ptr_d = ack_acc ? pick_idx + IDX_W'(1) : ptr_q;

    // Pointer register; set, clear and bulk write leave it alone.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority pick: lowest pending index wins.
    always_comb begin
        pick_idx = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Decode indices to one-hot masks and form the next pending vector;
    // the set is applied last so a new event always survives clear/ack/write.
    always_comb begin
        set_dec  = set_vld ? (ONE_HOT0 << set_idx)  : '0;
        clr_dec  = clr_vld ? (ONE_HOT0 << clr_idx)  : '0;
        ack_dec  = ack_acc ? (ONE_HOT0 << pick_idx) : '0;
        clr_mask = clr_dec | ack_dec;
        base     = wr_vld ? wr_data : pend_q;
        pend_d   = (base & ~clr_mask) | set_dec;
        dup_d    = set_vld & pend_q[set_idx] & ~clr_mask[set_idx];
    end

    // Pending vector and duplicate-set pulse registers.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            pend_q <= '0;
            dup_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            pend_q <= pend_d;
            dup_q  <= dup_d;
        end
    end

    assign pend_vec = pend_q;
    assign req_vld  = any_pend;
    assign req_idx  = pick_idx;
    assign dup_set  = dup_q;

endmodule

// File: tb/tb_tlu_dec_pend.sv
// Self-checking bench for tlu_dec_pend: directed vector table, hand-written
// multi-cycle sequences, randomized run against a behavioural model, and a
// small IDX_W=3 instance.
module tb_tlu_dec_pend;

`ifdef TLU_DEC_PEND_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        rclk = 1'b0;
    logic        arst_l = 1'b0;
    logic        set_vld = 1'b0, clr_vld = 1'b0, wr_vld = 1'b0, req_ack = 1'b0;
    logic [5:0]  set_idx = '0, clr_idx = '0;
    logic [63:0] wr_data = '0;
    logic [63:0] pend_vec;
    logic        req_vld, dup_set;
    logic [5:0]  req_idx;

    logic        s_set_vld = 1'b0, s_clr_vld = 1'b0, s_wr_vld = 1'b0, s_req_ack = 1'b0;
    logic [2:0]  s_set_idx = '0, s_clr_idx = '0;
    logic [7:0]  s_wr_data = '0;
    logic [7:0]  s_pend_vec;
    logic        s_req_vld, s_dup_set;
    logic [2:0]  s_req_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 rclk = ~rclk;

    tlu_dec_pend #(.IDX_W(6)) u_dut (
        .rclk(rclk), .arst_l(arst_l),
        .set_vld(set_vld), .set_idx(set_idx),
        .clr_vld(clr_vld), .clr_idx(clr_idx),
        .wr_vld(wr_vld), .wr_data(wr_data),
        .req_ack(req_ack),
        .pend_vec(pend_vec), .req_vld(req_vld), .req_idx(req_idx), .dup_set(dup_set)
    );

    tlu_dec_pend #(.IDX_W(3)) u_small (
        .rclk(rclk), .arst_l(arst_l),
        .set_vld(s_set_vld), .set_idx(s_set_idx),
        .clr_vld(s_clr_vld), .clr_idx(s_clr_idx),
        .wr_vld(s_wr_vld), .wr_data(s_wr_data),
        .req_ack(s_req_ack),
        .pend_vec(s_pend_vec), .req_vld(s_req_vld), .req_idx(s_req_idx), .dup_set(s_dup_set)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [5:0] si, input logic cv,
                         input logic [5:0] ci, input logic wv, input logic [63:0] wd,
                         input logic ack);
        set_vld = sv; set_idx = si; clr_vld = cv; clr_idx = ci;
        wr_vld = wv; wr_data = wd; req_ack = ack;
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic check_out(input string name, input logic [63:0] ep, input logic [5:0] ei);
        check({name, ".pend"}, pend_vec, ep);
        check({name, ".vld"}, 64'(req_vld), 64'(ep != 64'd0));
        check({name, ".idx"}, 64'(req_idx), 64'(ei));
    endtask

    // ---------------- behavioural reference model ----------------
    bit [63:0] m_pend;
    int        m_ptr;
    bit        m_dup;

    function automatic int m_pick();
        for (int k = 0; k < 64; k++) begin
            int j;
            j = (m_ptr + k) % 64;
            if (m_pend[j]) return j;
        end
        return 0;
    endfunction

    task automatic m_reset();
        m_pend = '0; m_ptr = 0; m_dup = 1'b0;
    endtask

    task automatic m_step(input bit sv, input int si, input bit cv, input int ci,
                          input bit wv, input bit [63:0] wd, input bit ack);
        int        p;
        bit        acc;
        bit [63:0] nxt;
        p   = m_pick();
        acc = ack && (m_pend != 0);
        nxt = wv ? wd : m_pend;
        if (cv)  nxt[ci] = 1'b0;
        if (acc) nxt[p]  = 1'b0;
        if (sv)  nxt[si] = 1'b1;
        m_dup = sv && m_pend[si] && !(cv && ci == si) && !(acc && p == si);
        if (acc && RR) m_ptr = (p + 1) % 64;
        m_pend = nxt;
    endtask

    task automatic do_reset();
        idle();
        arst_l = 1'b0;
        #2;
        arst_l = 1'b1;
        m_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        sv;
        logic [5:0]  si;
        logic        cv;
        logic [5:0]  ci;
        logic        wv;
        logic [63:0] wd;
        logic        ack;
        logic [63:0] ep;
        logic [5:0]  ei;
        logic        ed;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Table expectations hold for both pick modes: whenever more than one
        // entry is pending, the round-robin pointer is 0 or below every entry.
        tbl.push_back(vec_t'{1, 63, 0, 0,  0, 64'd0, 0, 64'h8000_0000_0000_0000, 63, 0});
        tbl.push_back(vec_t'{0, 0,  1, 63, 0, 64'd0, 0, 64'h0, 0, 0});
        tbl.push_back(vec_t'{1, 5,  0, 0,  0, 64'd0, 0, 64'h20, 5, 0});
        tbl.push_back(vec_t'{1, 2,  0, 0,  0, 64'd0, 0, 64'h24, 2, 0});
        tbl.push_back(vec_t'{1, 40, 0, 0,  0, 64'd0, 0, 64'h0000_0100_0000_0024, 2, 0});
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 64'd0, 1, 64'h0000_0100_0000_0020, 5, 0});
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 64'd0, 1, 64'h0000_0100_0000_0000, 40, 0});
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 64'd0, 1, 64'h0, 0, 0});
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 64'd0, 1, 64'h0, 0, 0});
        tbl.push_back(vec_t'{1, 9,  1, 9,  0, 64'd0, 0, 64'h200, 9, 0});
        tbl.push_back(vec_t'{1, 9,  0, 0,  0, 64'd0, 0, 64'h200, 9, 1});
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 64'd0, 0, 64'h200, 9, 0});
        tbl.push_back(vec_t'{1, 9,  0, 0,  0, 64'd0, 1, 64'h200, 9, 0});
        tbl.push_back(vec_t'{0, 0,  1, 9,  0, 64'd0, 0, 64'h0, 0, 0});
        tbl.push_back(vec_t'{1, 63, 0, 0,  0, 64'd0, 0, 64'h8000_0000_0000_0000, 63, 0});
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 64'd0, 1, 64'h0, 0, 0});
        tbl.push_back(vec_t'{1, 0,  1, 63, 1, 64'hFFFF_0000_0000_0000, 0, 64'h7FFF_0000_0000_0001, 0, 0});
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 64'd0, 1, 64'h7FFF_0000_0000_0000, 48, 0});
        tbl.push_back(vec_t'{0, 0,  0, 0,  1, 64'd0, 0, 64'h0, 0, 0});
        tbl.push_back(vec_t'{1, 3,  0, 0,  1, 64'd0, 0, 64'h8, 3, 0});
        tbl.push_back(vec_t'{0, 0,  1, 3,  0, 64'd0, 0, 64'h0, 0, 0});

        // Reset state.
        #12;
        check("rst.pend", pend_vec, 64'd0);
        check("rst.vld", 64'(req_vld), 64'd0);
        check("rst.idx", 64'(req_idx), 64'd0);
        check("rst.dup", 64'(dup_set), 64'd0);
        arst_l = 1'b1;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].sv, tbl[i].si, tbl[i].cv, tbl[i].ci, tbl[i].wv, tbl[i].wd, tbl[i].ack);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].ep, tbl[i].ei);
            check($sformatf("vec%0d.dup", i), 64'(dup_set), 64'(tbl[i].ed));
        end
        idle();

        // Asynchronous reset mid-run, with inputs ignored while held.
        drive(1'b1, 6'd17, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0);
        tick();
        drive(1'b1, 6'd17, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0);
        tick();
        check("arst.pre_dup", 64'(dup_set), 64'd1);
        #2;
        arst_l = 1'b0;
        #1;
        check_out("arst.async", 64'd0, 6'd0);
        check("arst.dup", 64'(dup_set), 64'd0);
        drive(1'b1, 6'd4, 1'b0, 6'd0, 1'b1, 64'hFFFF, 1'b0);
        tick();
        check_out("arst.held", 64'd0, 6'd0);
        idle();
        arst_l = 1'b1;
        m_reset();
        tick();

`ifdef TLU_DEC_PEND_RR_EN
        // Pointer wrap and circular search.
        drive(1, 62, 0, 0, 0, 0, 0); tick(); check_out("rr.s62", 64'h4000_0000_0000_0000, 62);
        drive(0, 0, 0, 0, 0, 0, 1);  tick(); check_out("rr.a62", 64'h0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);  tick(); check_out("rr.s1", 64'h2, 1);
        drive(1, 63, 0, 0, 0, 0, 0); tick(); check_out("rr.s63", 64'h8000_0000_0000_0002, 63);
        drive(0, 0, 0, 0, 0, 0, 1);  tick(); check_out("rr.a63", 64'h2, 1);
        drive(1, 63, 0, 0, 0, 0, 0); tick(); check_out("rr.s63b", 64'h8000_0000_0000_0002, 1);
        drive(1, 0, 0, 0, 0, 0, 1);  tick(); check_out("rr.a1", 64'h8000_0000_0000_0001, 63);
        drive(0, 0, 0, 0, 0, 0, 1);  tick(); check_out("rr.a63b", 64'h1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);  tick(); check_out("rr.a0", 64'h0, 0);
`else
        // Preemption by a higher-priority set before ack, then drain.
        drive(1, 63, 0, 0, 0, 0, 0); tick(); check_out("fx.s63", 64'h8000_0000_0000_0000, 63);
        drive(1, 1, 0, 0, 0, 0, 0);  tick(); check_out("fx.s1", 64'h8000_0000_0000_0002, 1);
        drive(1, 0, 0, 0, 0, 0, 0);  tick(); check_out("fx.s0", 64'h8000_0000_0000_0003, 0);
        drive(0, 0, 0, 0, 0, 0, 1);  tick(); check_out("fx.a0", 64'h8000_0000_0000_0002, 1);
        drive(0, 0, 0, 0, 0, 0, 1);  tick(); check_out("fx.a1", 64'h8000_0000_0000_0000, 63);
        drive(0, 0, 0, 0, 0, 0, 1);  tick(); check_out("fx.a63", 64'h0, 0);
`endif
        do_reset();
        tick();

        // Randomized run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            bit        sv, cv, wv, ack;
            int        si, ci;
            bit [63:0] wd;
            sv  = $urandom_range(0, 1) == 1;
            si  = $urandom_range(0, 63);
            cv  = $urandom_range(0, 3) == 0;
            ci  = $urandom_range(0, 63);
            wv  = $urandom_range(0, 15) == 0;
            wd  = {$urandom, $urandom};
            ack = $urandom_range(0, 1) == 1;
            drive(sv, 6'(si), cv, 6'(ci), wv, wd, ack);
            m_step(sv, si, cv, ci, wv, wd, ack);
            tick();
            check_out($sformatf("rnd%0d", c), m_pend, 6'(m_pick()));
            check($sformatf("rnd%0d.dup", c), 64'(dup_set), 64'(m_dup));
        end
        idle();

        // Small instance: ignored ack, top-index decode, drain.
        s_req_ack = 1'b1;
        tick();
        check("sm.ign.pend", 64'(s_pend_vec), 64'h0);
        check("sm.ign.vld", 64'(s_req_vld), 64'd0);
        s_req_ack = 1'b0; s_set_vld = 1'b1; s_set_idx = 3'd7;
        tick();
        check("sm.s7.pend", 64'(s_pend_vec), 64'h80);
        check("sm.s7.idx", 64'(s_req_idx), 64'd7);
        check("sm.s7.vld", 64'(s_req_vld), 64'd1);
        s_set_vld = 1'b0; s_wr_vld = 1'b1; s_wr_data = 8'h0F; s_clr_vld = 1'b1; s_clr_idx = 3'd0;
        tick();
        check("sm.wr.pend", 64'(s_pend_vec), 64'h0E);
        check("sm.wr.idx", 64'(s_req_idx), 64'd1);
        s_wr_vld = 1'b0; s_clr_vld = 1'b0; s_req_ack = 1'b1;
        tick();
        check("sm.ack.pend", 64'(s_pend_vec), 64'h0C);
        check("sm.ack.idx", 64'(s_req_idx), 64'd2);
        s_req_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
